// File: rtl/stack_arbiter.sv
// stack_arbiter: two-port fixed-priority arbiter onto a stack memory, with p1 starvation override.
module stack_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic [7:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [7:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata
);
  typedef enum logic {NORMAL, FORCE_P1} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic rd_v, rd_id;
  logic force_p1;
  assign force_p1 = state == FORCE_P1;
  // rst_n gates the grants so nothing reaches memory while reset is held
  assign p1_gnt = rst_n & p1_req & (force_p1 | ~p0_req);
  assign p0_gnt = rst_n & p0_req & ~(force_p1 & p1_req);
  always_comb begin
    cnt_nxt = (~p1_req | p1_gnt) ? 4'd0 : (cnt == 4'd15 ? cnt : cnt + 4'd1);
    state_nxt = state;
    if (force_p1) state_nxt = (p1_gnt | ~p1_req) ? NORMAL : FORCE_P1;
    else state_nxt = (cnt_nxt == 4'(STARVE_LIMIT)) ? FORCE_P1 : NORMAL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      cnt   <= '0;
      rd_v  <= 1'b0;
      rd_id <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd_v  <= (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
      rd_id <= p1_gnt;
    end
  end
  assign mem_addr  = p0_gnt ? p0_addr  : p1_gnt ? p1_addr  : '0;
  assign mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
  assign mem_we    = p0_gnt ? p0_we    : p1_gnt ? p1_we    : 1'b0;
  assign mem_size  = p0_gnt ? p0_size  : p1_gnt ? p1_size  : '0;
  assign p0_rvalid = rd_v & ~rd_id;
  assign p1_rvalid = rd_v & rd_id;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random checks of stack_arbiter against a one-cycle-latency memory model.
module tb_stack_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [7:0] p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic [1:0] p0_size = 0, p1_size = 0;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic [1:0] mem_size;
  logic [31:0] mem [256];
  logic wv [256];
  int checks = 0, failures = 0;
  stack_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_size(p0_size),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_size(p1_size),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  // unwritten locations read back as A5A5A5 followed by their address
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wv[mem_addr] <= 1'b1;
    end
    mem_rdata <= (wv[mem_addr] === 1'b1) ? mem[mem_addr] : {24'hA5A5A5, mem_addr};
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic contend(input int n, input int p1_at, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p0_req = 1; p0_we = 0; p0_addr = 8'h20;
      p1_req = 1; p1_we = 0; p1_addr = 8'h30;
      #1;
      chk({tag, "_p1gnt"}, p1_gnt, i == p1_at);
      chk({tag, "_p0gnt"}, p0_gnt, i != p1_at);
    end
  endtask
  initial begin
    logic ev0, ev1, g0, g1;
    int w0, w1;
    p0_req = 1; p0_we = 1;
    #1;
    chk("rst_p0gnt", p0_gnt, 0);
    chk("rst_memwe", mem_we, 0);
    repeat (2) @(negedge clk);
    chk("rst_p0rvalid", p0_rvalid, 0);
    chk("rst_p0rdata", p0_rdata, 0);
    rst_n = 1; p0_we = 0; p0_addr = 8'h10;
    #1;
    chk("rd_p0gnt", p0_gnt, 1);
    chk("rd_p1gnt", p1_gnt, 0);
    chk("rd_addr", mem_addr, 8'h10);
    chk("rd_we", mem_we, 0);
    @(negedge clk);
    p0_req = 0;
    chk("rd_rvalid", p0_rvalid, 1);
    chk("rd_rdata", p0_rdata, 32'hA5A5A510);
    chk("rd_p1rvalid", p1_rvalid, 0);
    @(negedge clk);
    chk("rd_rvalid_once", p0_rvalid, 0);
    chk("rd_rdata_zero", p0_rdata, 0);
    p0_req = 1; p0_we = 1; p0_addr = 8'h04; p0_wdata = 32'hDEADBEEF; p0_size = 2'd2;
    #1;
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 8'h04);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_size", mem_size, 2);
    @(negedge clk);
    p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 8'h04;
    #1;
    chk("wr_p1gnt", p1_gnt, 1);
    chk("wr_rd_we", mem_we, 0);
    chk("wr_no_rvalid", p0_rvalid, 0);
    @(negedge clk);
    p1_req = 0;
    chk("wr_p1rvalid", p1_rvalid, 1);
    chk("wr_p1rdata", p1_rdata, 32'hDEADBEEF);
    chk("wr_p0rvalid", p0_rvalid, 0);
    contend(5, 4, "starve_a");
    contend(5, 4, "starve_b");
    @(negedge clk);
    p0_req = 0; p1_req = 0;
    #1;
    chk("idle_we", mem_we, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_wdata, 0);
    chk("idle_size", mem_size, 0);
    contend(3, -1, "drop_pre");
    @(negedge clk);
    p1_req = 0;
    #1;
    chk("drop_p0gnt", p0_gnt, 1);
    contend(5, 4, "drop_post");
    contend(4, -1, "force_pre");
    @(negedge clk);
    p1_req = 0;
    #1;
    chk("force_drop_p0gnt", p0_gnt, 1);
    contend(5, 4, "force_post");
    @(negedge clk);
    p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 8'h11;
    #1;
    chk("rstrd_p1gnt", p1_gnt, 1);
    #2 rst_n = 0;
    #1;
    chk("rstrd_gnt_drop", p1_gnt, 0);
    chk("rstrd_we", mem_we, 0);
    chk("rstrd_addr", mem_addr, 0);
    @(negedge clk);
    chk("rstrd_rvalid", p1_rvalid, 0);
    chk("rstrd_rdata", p1_rdata, 0);
    rst_n = 1;
    #1;
    chk("rel_p1gnt", p1_gnt, 1);
    @(negedge clk);
    p1_req = 0;
    chk("rel_rvalid", p1_rvalid, 1);
    chk("rel_rdata", p1_rdata, 32'hA5A5A511);
    contend(3, -1, "cntrst_pre");
    @(negedge clk);
    rst_n = 0; p0_req = 0; p1_req = 0;
    @(negedge clk);
    rst_n = 1;
    contend(5, 4, "cntrst_post");
    @(negedge clk);
    p0_req = 0; p1_req = 0;
    ev0 = 0; ev1 = 0; g0 = 0; g1 = 0; w0 = 0; w1 = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk("rnd_rvalid0", p0_rvalid, ev0);
      chk("rnd_rvalid1", p1_rvalid, ev1);
      chk("rnd_rdata0", p0_rdata, ev0 ? mem_rdata : 32'h0);
      chk("rnd_rdata1", p1_rdata, ev1 ? mem_rdata : 32'h0);
      if (!p0_req || g0) begin
        p0_req = 1'($urandom); p0_we = 1'($urandom); p0_addr = 8'($urandom);
        p0_wdata = $urandom; p0_size = 2'($urandom); w0 = 0;
      end else w0++;
      if (!p1_req || g1) begin
        p1_req = 1'($urandom); p1_we = 1'($urandom); p1_addr = 8'($urandom);
        p1_wdata = $urandom; p1_size = 2'($urandom); w1 = 0;
      end else w1++;
      #1;
      chk("rnd_onehot", p0_gnt & p1_gnt, 0);
      chk("rnd_busy", p0_gnt | p1_gnt, p0_req | p1_req);
      if (p0_gnt) chk("rnd_wait0", w0 <= LIM, 1);
      if (p1_gnt) chk("rnd_wait1", w1 <= LIM, 1);
      g0 = p0_gnt; g1 = p1_gnt;
      ev0 = p0_gnt & ~p0_we;
      ev1 = p1_gnt & ~p1_we;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles of port 1 before it is forced ahead of port 0 (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports p0_req / p1_req  input  1  access request, held until granted.
REQ-005 SHALL have ports p0_addr / p1_addr  input  8  byte address.
REQ-006 SHALL have ports p0_wdata / p1_wdata  input  32  write data.
REQ-007 SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports p0_size / p1_size  input  2  window size code, passed through unchanged.
REQ-009 SHALL have ports p0_gnt / p1_gnt  output  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports p0_rvalid / p1_rvalid  output  1  read data valid (registered).
REQ-011 SHALL have ports p0_rdata / p1_rdata  output  32  read data.
REQ-012 SHALL have ports mem_addr  output  8, mem_wdata  output  32, mem_we  output  1, mem_size  output  2: stack memory command.
REQ-013 SHALL have port mem_rdata  input  32  stack memory read data, valid one cycle after the address cycle.

Function
REQ-014 SHALL grant at most one port per cycle; a grant and its memory command occur in the same cycle.
REQ-015 SHALL, in state NORMAL, grant p0 whenever p0_req=1, else p1 if p1_req=1.
REQ-016 SHALL keep a 4-bit starve counter: +1 each cycle p1_req=1 and p1_gnt=0, cleared on p1_gnt or when p1_req=0, saturating at 15.
REQ-017 SHALL move NORMAL -> FORCE_P1 on the edge where the counter reaches STARVE_LIMIT.
REQ-018 SHALL, in FORCE_P1, grant p1 if p1_req=1 regardless of p0_req, then return to NORMAL on the edge after that grant.
REQ-019 SHALL return FORCE_P1 -> NORMAL, counter cleared, if p1_req drops before being granted; p0 is then granted normally.
REQ-020 SHALL drive mem_addr/mem_wdata/mem_we/mem_size from the granted port's inputs; with no grant: mem_we=0, mem_addr=0, mem_wdata=0, mem_size=0.
REQ-021 SHALL record {read granted, port id} in a one-deep register; the cycle after a granted read, the matching pX_rvalid=1 for exactly one cycle.
REQ-022 SHALL drive pX_rdata = mem_rdata when pX_rvalid=1, else 0.
REQ-023 SHALL never assert rvalid for a granted write.
REQ-024 SHALL support back-to-back grants every cycle, either port, any read/write mix: throughput one access per cycle, read latency one cycle.
REQ-025 SHALL rely on the stack memory for write-to-read forwarding; issue order equals grant order, with no reordering or extra hazard stall.
REQ-026 SHALL ignore pX_addr/wdata/we/size of a port whose req=0.

Reset
REQ-027 SHALL, while rst_n=0, force state NORMAL, starve counter 0, read-tracking register cleared, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
REQ-028 SHALL hold p0_gnt=p1_gnt=0 and mem_we=0 combinationally while rst_n=0.
REQ-029 SHALL drop a read granted in the cycle reset asserts; no rvalid after reset release.
REQ-030 SHALL allow grants in the first cycle after rst_n rises.

Verification
REQ-031 p0 read addr 0x10 alone -> p0_gnt same cycle, mem_addr=0x10, mem_we=0; next cycle p0_rvalid=1, p0_rdata=mem_rdata.
REQ-032 p0 write 0x04 data 0xDEADBEEF size 2, then p1 read 0x04 next cycle -> mem_we=1 then 0; p1_rvalid=1 with 0xDEADBEEF returned by the memory model; p0_rvalid stays 0.
REQ-033 p0_req and p1_req held high continuously, STARVE_LIMIT=4 -> p0 granted 4 cycles, p1 granted the 5th, pattern repeats every 5 cycles.
REQ-034 p1_req high 3 cycles denied, then dropped -> counter returns to 0, no FORCE_P1 entry; later 4-cycle contention follows REQ-033 timing.
REQ-035 rst_n pulsed low during a granted p1 read -> p1_gnt, rvalid and counter go 0 immediately; no rvalid on release; first request after release granted in that cycle.
REQ-036 Random req/we traffic on both ports, 10000 cycles -> one grant per cycle max, every granted read gets exactly one rvalid on its own port, no port waits more than STARVE_LIMIT+1 cycles.
